// File: rtl/shot_brick_hit.sv
// shot_brick_hit: maps the in-flight shot position onto the brick grid,
// clears the struck brick, pulses a hit event and asks the shot unit to
// deactivate. Owns the live brick bitmap and the bricks-left count.
module shot_brick_hit #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int ORIGIN_X = 64,
    parameter int ORIGIN_Y = 48,
    parameter int BW_LOG2  = 6,
    parameter int BH_LOG2  = 4,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   level_load,
    input  logic [ROWS*COLS-1:0]   level_pattern,
    input  logic                   shot_active,
    input  logic [9:0]             shot_x,
    input  logic [9:0]             shot_y,
    output logic                   shot_kill,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_index,
    output logic [ROWS*COLS-1:0]   brick_map,
    output logic [CNT_W-1:0]       bricks_left,
    output logic                   cleared
);

    localparam int NBRICK = ROWS * COLS;

    // Grid bounds as 11-bit unsigned values so the upper bound cannot wrap.
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + (COLS << BW_LOG2));
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (ROWS << BH_LOG2));

    typedef enum logic [0:0] {
        ARMED     = 1'b0,
        KILL_WAIT = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NBRICK-1:0] p);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NBRICK; i++) begin
            c = c + CNT_W'(p[i]);
        end
        return c;
    endfunction

    logic [10:0]      x11, y11, dx, dy, col_w, row_w;
    logic             in_grid_d;
    logic [IDX_W-1:0] idx1_d;

    logic             v1_q, act1_q;
    logic [IDX_W-1:0] idx1_q;

    state_t                state_q;
    logic [NBRICK-1:0]     map_q;
    logic [CNT_W-1:0]      left_q;
    logic                  hit_q, kill_q;
    logic [IDX_W-1:0]      hidx_q;

    // Stage 1 combinational: grid containment test and brick index
    always_comb begin
        x11       = {1'b0, shot_x};
        y11       = {1'b0, shot_y};
        dx        = x11 - X_LO;
        dy        = y11 - Y_LO;
        col_w     = dx >> BW_LOG2;
        row_w     = dy >> BH_LOG2;
        in_grid_d = shot_active && (x11 >= X_LO) && (x11 < X_HI)
                                && (y11 >= Y_LO) && (y11 < Y_HI);
        idx1_d    = IDX_W'(row_w * 11'(COLS) + col_w);
    end

    // Stage 1 register: sampled position result plus the raw active flag
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q   <= 1'b0;
            act1_q <= 1'b0;
        end else begin
            v1_q   <= level_load ? 1'b0 : in_grid_d;
            act1_q <= shot_active;
        end
        idx1_q <= idx1_d;
    end

    // Stage 2 FSM: brick clear, hit pulse and kill handshake with the shot unit
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARMED;
            map_q   <= '1;
            left_q  <= CNT_W'(NBRICK);
            hit_q   <= 1'b0;
            kill_q  <= 1'b0;
            hidx_q  <= '0;
        end else if (level_load) begin
            // A load overrides any hit pending in this same cycle.
            state_q <= ARMED;
            map_q   <= level_pattern;
            left_q  <= popcount(level_pattern);
            hit_q   <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (v1_q && map_q[idx1_q]) begin
                        map_q[idx1_q] <= 1'b0;
                        left_q        <= left_q - CNT_W'(1);
                        hit_q         <= 1'b1;
                        hidx_q        <= idx1_q;
                        kill_q        <= 1'b1;
                        state_q       <= KILL_WAIT;
                    end else begin
                        hit_q <= 1'b0;
                    end
                end
                KILL_WAIT: begin
                    // Ignore positions until the shot unit confirms it is dead,
                    // so one shot can never destroy two bricks.
                    hit_q <= 1'b0;
                    if (!act1_q) begin
                        kill_q  <= 1'b0;
                        state_q <= ARMED;
                    end
                end
                default: begin
                    state_q <= ARMED;
                    hit_q   <= 1'b0;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign shot_kill   = kill_q;
    assign hit         = hit_q;
    assign hit_index   = hidx_q;
    assign brick_map   = map_q;
    assign bricks_left = left_q;
    assign cleared     = (left_q == '0);

endmodule

// File: tb/tb_shot_brick_hit.sv
// Testbench for shot_brick_hit: directed scenarios plus randomized shots,
// all checked against a behavioural model of the brick wall.
module tb_shot_brick_hit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        level_load = 1'b0;
    logic [31:0] level_pattern = '0;
    logic        shot_active = 1'b0;
    logic [9:0]  shot_x = '0;
    logic [9:0]  shot_y = '0;
    logic        shot_kill, hit, cleared;
    logic [4:0]  hit_index;
    logic [31:0] brick_map;
    logic [5:0]  bricks_left;

    shot_brick_hit dut (
        .clock(clock), .reset(reset), .level_load(level_load),
        .level_pattern(level_pattern), .shot_active(shot_active),
        .shot_x(shot_x), .shot_y(shot_y), .shot_kill(shot_kill), .hit(hit),
        .hit_index(hit_index), .brick_map(brick_map),
        .bricks_left(bricks_left), .cleared(cleared)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Behavioural model: the wall as an array of bricks, one pending sample
    bit m_brick [32];
    bit m_hit, m_kill, m_waiting;
    int m_idx;
    bit s_valid, s_act;
    int s_idx;

    int hit_cnt;
    int last_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_left();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_brick[i];
        return n;
    endfunction

    function automatic logic [31:0] model_map();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_brick[i];
        return m;
    endfunction

    // Advance the model by one clock edge given the inputs present at that edge
    task automatic model_edge(input bit rst, input bit ld, input logic [31:0] pat,
                              input bit act, input int x, input int y);
        bit inside_grid;
        inside_grid = act && x >= 64 && x < 64 + 8 * 64 && y >= 48 && y < 48 + 4 * 16;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_brick[i] = 1'b1;
            m_hit = 0; m_kill = 0; m_idx = 0; m_waiting = 0;
            s_valid = 0; s_act = 0;
        end else if (ld) begin
            for (int i = 0; i < 32; i++) m_brick[i] = pat[i];
            m_hit = 0; m_kill = 0; m_waiting = 0;
            s_valid = 0; s_act = act;
        end else begin
            m_hit = 0;
            if (!m_waiting) begin
                if (s_valid && m_brick[s_idx]) begin
                    m_brick[s_idx] = 0;
                    m_hit = 1; m_idx = s_idx; m_kill = 1; m_waiting = 1;
                end
            end else if (!s_act) begin
                m_kill = 0; m_waiting = 0;
            end
            s_valid = inside_grid;
            s_act = act;
        end
        if (inside_grid) s_idx = ((y - 48) / 16) * 8 + (x - 64) / 64;
    endtask

    // Drive one cycle of inputs, clock it, then compare every output
    task automatic cyc(input bit rst, input bit ld, input logic [31:0] pat,
                       input bit act, input int x, input int y);
        int left;
        reset = rst; level_load = ld; level_pattern = pat;
        shot_active = act; shot_x = 10'(x); shot_y = 10'(y);
        @(posedge clock);
        model_edge(rst, ld, pat, act, x, y);
        #1;
        left = model_left();
        check("hit", 32'(hit), 32'(m_hit));
        check("shot_kill", 32'(shot_kill), 32'(m_kill));
        check("hit_index", 32'(hit_index), 32'(m_idx));
        check("brick_map", brick_map, model_map());
        check("bricks_left", 32'(bricks_left), 32'(left));
        check("cleared", 32'(cleared), 32'(left == 0));
        if (hit === 1'b1) begin
            hit_cnt++;
            last_idx = int'(hit_index);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_brick[i] = 1'b1;
        m_hit = 0; m_kill = 0; m_idx = 0; m_waiting = 0;
        s_valid = 0; s_act = 0; s_idx = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_map", brick_map, 32'hFFFF_FFFF);
        check("rst_left", 32'(bricks_left), 32);
        check("rst_cleared", 32'(cleared), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_kill", 32'(shot_kill), 0);

        // Single shot at (200,70): index 10, two-cycle latency, kill handshake
        hit_cnt = 0;
        cyc(0, 0, 0, 1, 200, 70);
        check("lat_early", 32'(hit), 0);
        cyc(0, 0, 0, 1, 200, 70);
        check("lat_hit", 32'(hit), 1);
        check("lat_idx", 32'(hit_index), 10);
        check("lat_bit10", 32'(brick_map[10]), 0);
        check("lat_left", 32'(bricks_left), 31);
        cyc(0, 0, 0, 1, 200, 70);
        cyc(0, 0, 0, 1, 200, 70);
        check("kill_hold", 32'(shot_kill), 1);
        check("single_hit", 32'(hit_cnt), 1);
        cyc(0, 0, 0, 0, 200, 70);
        check("kill_still", 32'(shot_kill), 1);
        cyc(0, 0, 0, 0, 200, 70);
        check("kill_release", 32'(shot_kill), 0);

        // Vertical sweep at column 0 with bricks 24 and 16 already gone
        cyc(0, 1, 32'hFEFE_FFFF, 0, 0, 0);
        hit_cnt = 0; last_idx = -1;
        for (int y = 120; y >= 40; y--) cyc(0, 0, 0, 1, 100, y);
        check("sweep_hits", 32'(hit_cnt), 1);
        check("sweep_idx", 32'(last_idx), 8);
        idle(3);

        // Boundary positions just outside the grid
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        hit_cnt = 0;
        cyc(0, 0, 0, 1, 63, 70);  idle(3);
        cyc(0, 0, 0, 1, 576, 70); idle(3);
        cyc(0, 0, 0, 1, 200, 112); idle(3);
        cyc(0, 0, 0, 1, 200, 47); idle(3);
        check("bound_out", 32'(hit_cnt), 0);
        cyc(0, 0, 0, 1, 575, 111); idle(3);
        check("bound_in_cnt", 32'(hit_cnt), 1);
        check("bound_in_idx", 32'(last_idx), 31);

        // Load colliding with a pending hit on index 5
        hit_cnt = 0;
        cyc(0, 0, 0, 1, 394, 50);
        cyc(0, 1, 32'h0000_0001, 0, 0, 0);
        idle(2);
        check("load_nohit", 32'(hit_cnt), 0);
        check("load_map", brick_map, 32'h1);
        check("load_left", 32'(bricks_left), 1);
        cyc(0, 0, 0, 1, 70, 50); idle(3);
        check("last_idx", 32'(last_idx), 0);
        check("last_left", 32'(bricks_left), 0);
        check("last_cleared", 32'(cleared), 1);

        // Empty wall load: cleared right away
        cyc(0, 1, 32'h0, 0, 0, 0);
        check("empty_cleared", 32'(cleared), 1);

        // Reset while waiting for the kill to land
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 1, 200, 70);
        cyc(0, 0, 0, 1, 200, 70);
        cyc(0, 0, 0, 1, 200, 70);
        check("kw_kill", 32'(shot_kill), 1);
        cyc(1, 0, 0, 1, 200, 70);
        check("rst_kw_kill", 32'(shot_kill), 0);
        check("rst_kw_map", brick_map, 32'hFFFF_FFFF);
        hit_cnt = 0;
        cyc(0, 0, 0, 1, 200, 70);
        cyc(0, 0, 0, 1, 200, 70);
        check("rearm_hit", 32'(hit), 1);
        check("rearm_idx", 32'(hit_index), 10);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, l, a;
            r = ($urandom_range(0, 399) == 0);
            l = ($urandom_range(0, 149) == 0);
            a = ($urandom_range(0, 3) != 0);
            cyc(r, l, $urandom, a, int'($urandom_range(0, 700)), int'($urandom_range(0, 150)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shot_brick_hit.md
Name: shot_brick_hit

Overview:
- Downstream consumer of the paddle-shot unit. Each cycle it samples the shot position and active flag, and maps the point onto the brick grid.
- On a hit it clears the brick, pulses a hit event and asserts a kill request back to the shot unit.
- It owns the authoritative brick bitmap. The renderer reads that bitmap, and the level sequencer uses the bricks-left count.

Parameters:
- COLS, 8, brick columns.
- ROWS, 4, brick rows.
- ORIGIN_X, 64, left pixel of the grid.
- ORIGIN_Y, 48, top pixel of the grid.
- BW_LOG2, 6, log2 of brick width (64 px).
- BH_LOG2, 4, log2 of brick height (16 px).
- IDX_W, 5, width of a brick index (ceil log2 of ROWS*COLS).
- CNT_W, 6, width of the bricks-left counter (holds up to ROWS*COLS).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, reset, synchronous, active-high; clock clock.
- level_load, input, 1, one-cycle request to load a new wall.
- level_pattern, input, ROWS*COLS, wall to load; bit i is brick i.
- shot_active, input, 1, shot in flight.
- shot_x, input, 10, shot pixel x.
- shot_y, input, 10, shot pixel y.
- shot_kill, output, 1, request to the shot unit to deactivate.
- hit, output, 1, one-cycle pulse per brick destroyed.
- hit_index, output, IDX_W, index of the last brick destroyed.
- brick_map, output, ROWS*COLS, live bitmap; index = row*COLS + col.
- bricks_left, output, CNT_W, number of set bits in brick_map.
- cleared, output, 1, high when bricks_left == 0.

Behaviour:
- Reset values:
  - brick_map all ones; bricks_left = ROWS*COLS.
  - hit = 0, shot_kill = 0, hit_index = 0, cleared = 0.
  - FSM in ARMED; pipeline valid bit = 0.
- Stage 1 (registered every cycle):
  - in_grid = shot_active && ORIGIN_X <= shot_x < ORIGIN_X + (COLS << BW_LOG2) && ORIGIN_Y <= shot_y < ORIGIN_Y + (ROWS << BH_LOG2).
  - col = (shot_x - ORIGIN_X) >> BW_LOG2; row = (shot_y - ORIGIN_Y) >> BH_LOG2.
  - All comparisons are unsigned 11-bit, so there is no wrap on the upper bound.
  - Stage 1 registers v1 = in_grid and idx1 = row*COLS + col.
- Stage 2 / FSM:
  - ARMED: if v1 && brick_map[idx1]:
    - clear that bit; decrement bricks_left;
    - hit = 1 for one cycle; hit_index = idx1; shot_kill = 1;
    - go to KILL_WAIT.
  - ARMED, otherwise: stay; hit = 0.
  - KILL_WAIT:
    - shot_kill stays high and hit stays 0; all stage-1 results are ignored, which prevents a double hit while the kill propagates.
    - When a stage-1 sample shows shot_active == 0, deassert shot_kill and return to ARMED. That sample is registered into stage 1 one cycle after the shot unit drops active.
- Latency: a position sampled in cycle N produces hit and shot_kill in cycle N+2. The brick_map bit clears on the same edge that asserts hit.
- Empty bricks: a shot inside the grid over a cleared brick gives no response and keeps flying.
- level_load (takes priority over everything in the same cycle):
  - brick_map <= level_pattern; bricks_left <= popcount(level_pattern);
  - v1 <= 0; hit <= 0; shot_kill <= 0; FSM <= ARMED.
  - A hit that is pending in stage 2 in that same cycle is discarded.
- cleared is combinational from bricks_left == 0. A load of an all-zero pattern gives cleared = 1 immediately.
- bricks_left never underflows: a decrement only happens when the bit was set.
- Reset mid-operation (including in KILL_WAIT) returns everything to its reset values on the next edge.

Test Plan:
- After reset: brick_map = 0xFFFFFFFF, bricks_left = 32, cleared = 0, hit = 0, shot_kill = 0.
- Shot at x=200, y=70, active, for 1 cycle:
  - hit pulses 2 cycles later with hit_index = 10; brick_map bit 10 = 0; bricks_left = 31; shot_kill high.
  - shot_kill holds until shot_active drops, then clears one cycle after that sample.
- Shot sweeps y from 120 down to 40 at x=100 (col 0), with bits 24 and 16 preset clear:
  - first hit has hit_index = 8; only one hit while in KILL_WAIT, even though the y sweep continues through row 0.
- Boundary positions (active):
  - x=63 or x=576 or y=112, with y/x otherwise inside the grid: no hit.
  - x=575, y=111: hit on index 31.
- level_load with pattern 0x00000001 in the same cycle as a pending hit on index 5:
  - no hit; brick_map = 0x1; bricks_left = 1.
  - A following shot at x=70, y=50 hits index 0; then bricks_left = 0 and cleared = 1.
- Reset asserted while in KILL_WAIT: next cycle shot_kill = 0, brick_map = all ones, FSM armed; a new shot at index 10 hits normally.
